mem_stage: RTL
==============

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state updates on rising edge; rst  in  1  synchronous, active-high reset.
REQ-002 SHALL have ports: ex_mem_reg  in  ex_mem_stage_reg_t  upstream latch, with fields valid, opcode, funct3, alu_result[31:0], rs2_v[31:0], rd_s[4:0], regf_we.
REQ-003 SHALL have ports: dmem_addr  out  32  word-aligned request address; dmem_rmask  out  4  byte read mask; dmem_wmask  out  4  byte write mask; dmem_wdata  out  32  lane-shifted store data.
REQ-004 SHALL have ports: dmem_resp  in  1  one-cycle completion strobe for the outstanding access.
REQ-005 SHALL have ports: mem_wb_reg  out  mem_wb_stage_reg_t  registered downstream latch, with fields valid, opcode, funct3, unconst_addr, alu_result, rd_s, regf_we, mem_rmask, mem_wmask.
REQ-006 SHALL have ports: freeze  out  1  global pipeline hold; stall_cycles  out  32  freeze-cycle counter.

Function
REQ-007 SHALL implement FSM states IDLE and WAIT, with reset state IDLE.
REQ-008 SHALL define issue = ex_mem_reg.valid AND opcode in {op_b_load, op_b_store} AND aligned AND NOT freeze.
REQ-009 SHALL define aligned: byte ops always; half ops need alu_result[0]=0; word ops need alu_result[1:0]=00.
REQ-010 SHALL drive dmem_addr = {alu_result[31:2],2'b00} combinationally, with masks zero unless issue=1.
REQ-011 SHALL set masks on issue as: lb/lbu/sb 4'b0001<<off; lh/lhu/sh 4'b0011<<(2*alu_result[1]); lw/sw 4'b1111, where off = alu_result[1:0]; loads drive rmask only, stores drive wmask only.
REQ-012 SHALL set dmem_wdata to rs2_v<<(8*off) for sb, rs2_v<<(16*alu_result[1]) for sh, rs2_v for sw, and 0 otherwise.
REQ-013 SHALL assert a nonzero mask for exactly one cycle per memory instruction, with no re-issue while waiting.
REQ-014 SHALL treat a misaligned load/store as no access: masks 0, no state change, and the instruction passes with mem_rmask=mem_wmask=0.
REQ-015 SHALL take IDLE->WAIT on issue and otherwise stay in IDLE; dmem_resp in IDLE is ignored.
REQ-016 SHALL make WAIT transitions: with dmem_resp=0, stay and assert freeze=1; with dmem_resp=1 and issue, stay in WAIT (back-to-back); with dmem_resp=1 and no issue, go to IDLE.
REQ-017 SHALL compute freeze = (state==WAIT) AND NOT dmem_resp combinationally, so a response cycle never freezes.
REQ-018 SHALL, on each edge with freeze=0, load mem_wb_reg from ex_mem_reg, with unconst_addr=alu_result and masks as issued that cycle.
REQ-019 SHALL hold mem_wb_reg unchanged when freeze=1.
REQ-020 SHALL increment stall_cycles by 1 on each edge with freeze=1, wrapping at 2^32-1 -> 0.
REQ-021 SHALL treat an invalid ex_mem_reg (valid=0) as a bubble: no issue, mem_wb_reg.valid=0 on load.
REQ-022 SHALL, for a non-memory opcode, issue no access and pass through in one cycle.

Reset
REQ-023 SHALL, on rst=1 at an edge: state=IDLE, mem_wb_reg all fields 0 (valid=0), stall_cycles=0.
REQ-024 SHALL force freeze=0 and masks 0 in the cycle after reset regardless of prior state.
REQ-025 SHALL give rst priority over dmem_resp and issue in the same cycle.
REQ-026 SHALL ignore a dmem_resp arriving after a reset taken in WAIT (state IDLE).

Verification
REQ-027 SHALL be verified by: lw, alu_result=0x1000_0008, resp after 3 cycles -> one-cycle rmask=1111, addr=0x1000_0008, freeze high for 2 cycles, stall_cycles=2, mem_wb_reg held.
REQ-028 SHALL be verified by: sb, alu_result=0x...03, rs2_v=0x0000_00AB -> wmask=1000, wdata=0xAB00_0000; sh at offset 2, rs2_v=0x1234 -> wmask=1100, wdata=0x1234_0000.
REQ-029 SHALL be verified by: two back-to-back loads, zero-wait resp -> second request in the first response cycle, freeze never asserted, state stays WAIT.
REQ-030 SHALL be verified by: lw at offset 2 -> masks 0, no freeze, mem_wb_reg.valid=1 with zero masks next cycle.
REQ-031 SHALL be verified by: rst asserted in WAIT, then dmem_resp pulsed -> state IDLE, freeze 0, mem_wb_reg.valid 0, stall_cycles 0.
REQ-032 SHALL be verified by: ALU op/bubble stream -> no masks ever nonzero, mem_wb_reg tracks ex_mem_reg with 1-cycle latency.

Source files
------------

// File: rtl/mem_stage.sv
// Memory stage: issues one data-memory access per load/store and freezes the
// pipeline until the matching dmem_resp strobe arrives.
package mem_stage_pkg;
   localparam logic [6:0] op_b_load  = 7'b0000011;
   localparam logic [6:0] op_b_store = 7'b0100011;

   typedef struct packed {
      logic        valid;
      logic [6:0]  opcode;
      logic [2:0]  funct3;
      logic [31:0] alu_result;
      logic [31:0] rs2_v;
      logic [4:0]  rd_s;
      logic        regf_we;
   } ex_mem_stage_reg_t;

   typedef struct packed {
      logic        valid;
      logic [6:0]  opcode;
      logic [2:0]  funct3;
      logic [31:0] unconst_addr;
      logic [31:0] alu_result;
      logic [4:0]  rd_s;
      logic        regf_we;
      logic [3:0]  mem_rmask;
      logic [3:0]  mem_wmask;
   } mem_wb_stage_reg_t;
endpackage

module mem_stage
   import mem_stage_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  ex_mem_stage_reg_t ex_mem_reg,
   output logic [31:0]       dmem_addr,
   output logic [3:0]        dmem_rmask,
   output logic [3:0]        dmem_wmask,
   output logic [31:0]       dmem_wdata,
   input  logic              dmem_resp,
   output mem_wb_stage_reg_t mem_wb_reg,
   output logic              freeze,
   output logic [31:0]       stall_cycles
);

   typedef enum logic {IDLE, WAIT} state_t;

   state_t      state, state_next;
   logic        is_load, is_store, size_ok, aligned, issue;
   logic [1:0]  off;
   logic [2:0]  f3;
   logic [3:0]  mask;

   always_comb begin
      off      = ex_mem_reg.alu_result[1:0];
      f3       = ex_mem_reg.funct3;
      is_load  = ex_mem_reg.valid && (ex_mem_reg.opcode == op_b_load);
      is_store = ex_mem_reg.valid && (ex_mem_reg.opcode == op_b_store);
      // funct3[2] selects unsigned loads of byte/half only; no encoding for stores
      size_ok  = (f3[1:0] != 2'b11) && !(f3[2] && (is_store || f3[1]));
      mask     = 4'b0000;
      aligned  = 1'b0;
      case (f3[1:0])
         2'b00: begin mask = 4'b0001 << off;              aligned = 1'b1;          end
         2'b01: begin mask = 4'b0011 << {off[1], 1'b0};   aligned = !off[0];       end
         2'b10: begin mask = 4'b1111;                     aligned = (off == 2'b00); end
         default: ;
      endcase

      freeze     = (state == WAIT) && !dmem_resp;
      issue      = (is_load || is_store) && size_ok && aligned && !freeze;
      dmem_addr  = {ex_mem_reg.alu_result[31:2], 2'b00};
      dmem_rmask = (issue && is_load)  ? mask : 4'b0000;
      dmem_wmask = (issue && is_store) ? mask : 4'b0000;

      dmem_wdata = '0;
      if (issue && is_store) begin
         case (f3[1:0])
            2'b00:   dmem_wdata = ex_mem_reg.rs2_v << {off, 3'b000};
            2'b01:   dmem_wdata = ex_mem_reg.rs2_v << {off[1], 4'b0000};
            default: dmem_wdata = ex_mem_reg.rs2_v;
         endcase
      end

      // A response cycle may issue the next access, keeping the FSM in WAIT
      state_next = state;
      if (state == IDLE) begin
         if (issue) state_next = WAIT;
      end else if (dmem_resp && !issue) begin
         state_next = IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         mem_wb_reg   <= '0;
         stall_cycles <= '0;
      end else begin
         state <= state_next;
         if (freeze) begin
            stall_cycles <= stall_cycles + 32'd1;
         end else begin
            mem_wb_reg.valid        <= ex_mem_reg.valid;
            mem_wb_reg.opcode       <= ex_mem_reg.opcode;
            mem_wb_reg.funct3       <= ex_mem_reg.funct3;
            mem_wb_reg.unconst_addr <= ex_mem_reg.alu_result;
            mem_wb_reg.alu_result   <= ex_mem_reg.alu_result;
            mem_wb_reg.rd_s         <= ex_mem_reg.rd_s;
            mem_wb_reg.regf_we      <= ex_mem_reg.regf_we;
            mem_wb_reg.mem_rmask    <= dmem_rmask;
            mem_wb_reg.mem_wmask    <= dmem_wmask;
         end
      end
   end

endmodule
